// File: rtl/ddr_issue_pkg.sv
// Shared constants for the request issuer: source-select encodings and the
// default payload width used by the issuer and its input FIFOs.
package ddr_issue_pkg;

  // Encoding of out_sel and of the round-robin pointer.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Default payload width per request.
  localparam int DW_DEFAULT = 8;

  // Returns the source that should win arbitration this cycle.
  // A source that is empty never wins; when both have data the
  // round-robin pointer decides.
  function automatic logic pick_source(input logic a_avail,
                                       input logic b_avail,
                                       input logic rr_ptr);
    if (a_avail && b_avail) begin
      return rr_ptr;
    end
    return b_avail ? SEL_B : SEL_A;
  endfunction

endpackage : ddr_issue_pkg

// File: rtl/req_fifo.sv
// Synchronous request FIFO with registered full/empty flags.
// Writes are dropped while full; reads are ignored while empty.
// Push and pop on the same edge are both honoured when not full.
module req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and flags alone define what is valid.
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule : req_fifo

// File: rtl/ddr_req_issuer.sv
// Producer side of the select/capture stage. Requests from sources A and B
// are buffered in small FIFOs, arbitrated round-robin, and presented as one
// registered {sel, data} slot that holds while the capture stage reports
// congestion. A sticky flag records congestion that lasts TIMEOUT cycles.
module ddr_req_issuer
  import ddr_issue_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          cong,
  output logic          out_valid,
  output logic          out_sel,
  output logic [DW-1:0] out_data,
  output logic          cong_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [DW-1:0] a_rdata;
  logic [DW-1:0] b_rdata;
  logic          a_full;
  logic          b_full;
  logic          a_empty;
  logic          b_empty;
  logic          a_pop;
  logic          b_pop;
  logic          a_avail;
  logic          b_avail;
  logic          slot_free;
  logic          load;
  logic          grant;
  logic          rr_ptr;
  logic [TW-1:0] to_cnt;

  // Source A buffer.
  req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (a_valid),
    .wdata (a_data),
    .pop   (a_pop),
    .rdata (a_rdata),
    .full  (a_full),
    .empty (a_empty)
  );

  // Source B buffer.
  req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (b_valid),
    .wdata (b_data),
    .pop   (b_pop),
    .rdata (b_rdata),
    .full  (b_full),
    .empty (b_empty)
  );

  // Ready comes straight from the registered full flags.
  assign a_ready = !a_full;
  assign b_ready = !b_full;

  // The slot can take a new request when empty or being consumed this edge.
  assign a_avail   = !a_empty;
  assign b_avail   = !b_empty;
  assign slot_free = !out_valid || !cong;
  assign load      = slot_free && (a_avail || b_avail);
  assign grant     = pick_source(a_avail, b_avail, rr_ptr);
  assign a_pop     = load && (grant == SEL_A);
  assign b_pop     = load && (grant == SEL_B);

  // Output slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sel   <= SEL_A;
      out_data  <= '0;
      rr_ptr    <= SEL_A;
    end else if (slot_free) begin
      out_valid <= a_avail || b_avail;
      if (load) begin
        out_sel  <= grant;
        out_data <= (grant == SEL_B) ? b_rdata : a_rdata;
        rr_ptr   <= (grant == SEL_B) ? SEL_A : SEL_B;
      end
    end
  end

  // Congestion timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt   <= '0;
      cong_err <= 1'b0;
    end else if (!cong) begin
      to_cnt <= '0;
    end else if (out_valid && (to_cnt != TW'(TIMEOUT))) begin
      to_cnt <= to_cnt + TW'(1);
      if (to_cnt == TW'(TIMEOUT - 1)) begin
        cong_err <= 1'b1;
      end
    end
  end

endmodule : ddr_req_issuer

// File: tb/tb_ddr_req_issuer.sv
// Directed bench for ddr_req_issuer: handshake, round-robin order,
// congestion hold, FIFO-full backpressure, timeout flag and async reset.
module tb_ddr_req_issuer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          cong;
  logic          out_valid;
  logic          out_sel;
  logic [DW-1:0] out_data;
  logic          cong_err;

  int checks = 0;
  int errors = 0;

  ddr_req_issuer #(
    .DW      (DW),
    .DEPTH   (2),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .cong      (cong),
    .out_valid (out_valid),
    .out_sel   (out_sel),
    .out_data  (out_data),
    .cong_err  (cong_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge; inputs and samples sit 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic s, input logic [DW-1:0] d);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".sel"},   32'(out_sel),   32'(s));
    check({tag, ".data"},  32'(out_data),  32'(d));
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    cong    = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state, single A request latency.
    do_reset();
    check_out("rst", 1'b0, 1'b0, 8'h00);
    check("rst.a_ready", 32'(a_ready), 32'd1);
    check("rst.b_ready", 32'(b_ready), 32'd1);
    check("rst.cong_err", 32'(cong_err), 32'd0);
    a_valid = 1'b1; a_data = 8'h11;
    step();
    a_valid = 1'b0;
    check("t1.after_push.valid", 32'(out_valid), 32'd0);
    step();
    check_out("t1.out", 1'b1, 1'b0, 8'h11);
    step();
    check("t1.drained.valid", 32'(out_valid), 32'd0);

    // 2. Round-robin interleave with both sources loaded.
    do_reset();
    a_valid = 1'b1; a_data = 8'h01;
    b_valid = 1'b1; b_data = 8'h81;
    step();
    a_data = 8'h02; b_data = 8'h82;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    check_out("t2.o0", 1'b1, 1'b0, 8'h01);
    step();
    check_out("t2.o1", 1'b1, 1'b1, 8'h81);
    step();
    check_out("t2.o2", 1'b1, 1'b0, 8'h02);
    step();
    check_out("t2.o3", 1'b1, 1'b1, 8'h82);
    step();
    check("t2.end.valid", 32'(out_valid), 32'd0);

    // 3. Congestion holds the slot; consumed exactly once.
    do_reset();
    b_valid = 1'b1; b_data = 8'h55;
    step();
    b_valid = 1'b0;
    step();
    check_out("t3.load", 1'b1, 1'b1, 8'h55);
    cong = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_out($sformatf("t3.hold%0d", i), 1'b1, 1'b1, 8'h55);
    end
    cong = 1'b0;
    step();
    check("t3.consumed.valid", 32'(out_valid), 32'd0);
    step();
    check("t3.once.valid", 32'(out_valid), 32'd0);

    // 4. FIFO-full backpressure on A while the slot is stuck.
    do_reset();
    a_valid = 1'b1; a_data = 8'hA0;
    step();
    a_valid = 1'b0;
    step();
    check_out("t4.slot", 1'b1, 1'b0, 8'hA0);
    cong = 1'b1;
    a_valid = 1'b1; a_data = 8'h31;
    step();
    check("t4.ready_after1", 32'(a_ready), 32'd1);
    a_data = 8'h32;
    step();
    check("t4.ready_after2", 32'(a_ready), 32'd0);
    a_data = 8'h33;
    step();
    check("t4.ready_full", 32'(a_ready), 32'd0);
    check_out("t4.still", 1'b1, 1'b0, 8'hA0);
    a_valid = 1'b0;
    cong = 1'b0;
    step();
    check_out("t4.d0", 1'b1, 1'b0, 8'h31);
    check("t4.ready_popped", 32'(a_ready), 32'd1);
    step();
    check_out("t4.d1", 1'b1, 1'b0, 8'h32);
    step();
    check("t4.no_third.valid", 32'(out_valid), 32'd0);

    // 5. Timeout: 15-cycle burst stays clear, 16-cycle burst sets the flag.
    do_reset();
    a_valid = 1'b1; a_data = 8'h77;
    step();
    a_data = 8'h78;
    step();
    a_valid = 1'b0;
    check_out("t5.first", 1'b1, 1'b0, 8'h77);
    cong = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("t5.short%0d", i), 32'(cong_err), 32'd0);
    end
    cong = 1'b0;
    step();
    check_out("t5.second", 1'b1, 1'b0, 8'h78);
    check("t5.short_end", 32'(cong_err), 32'd0);
    cong = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("t5.long%0d", i), 32'(cong_err), 32'd0);
    end
    step();
    check("t5.edge16", 32'(cong_err), 32'd1);
    cong = 1'b0;
    step();
    check("t5.sticky", 32'(cong_err), 32'd1);
    check("t5.drained", 32'(out_valid), 32'd0);
    repeat (3) step();
    check("t5.sticky_later", 32'(cong_err), 32'd1);

    // 6. Async reset mid-stream with both FIFOs holding data.
    do_reset();
    a_valid = 1'b1; a_data = 8'h41;
    b_valid = 1'b1; b_data = 8'hC1;
    step();
    a_data = 8'h42; b_data = 8'hC2;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    cong = 1'b1;
    step();
    check_out("t6.pre", 1'b1, 1'b0, 8'h41);
    #2 rst = 1'b0;
    #1;
    check_out("t6.async", 1'b0, 1'b0, 8'h00);
    check("t6.a_ready", 32'(a_ready), 32'd1);
    check("t6.b_ready", 32'(b_ready), 32'd1);
    check("t6.cong_err", 32'(cong_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cong = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6.stale%0d", i), 32'(out_valid), 32'd0);
    end
    b_valid = 1'b1; b_data = 8'h99;
    step();
    b_valid = 1'b0;
    step();
    check_out("t6.fresh", 1'b1, 1'b1, 8'h99);
    step();
    check("t6.fresh_only", 32'(out_valid), 32'd0);

    // Congestion with an empty slot never advances the timeout.
    cong = 1'b1;
    repeat (20) step();
    check("t6.idle_cong", 32'(cong_err), 32'd0);
    cong = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ddr_req_issuer
